display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter N_DIG, default 6: number of multiplexed 7-segment digits.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per digit slot.
REQ-003 Parameter GUARD, default 4: anti-ghost dead cycles at the start of each slot.
REQ-004 Parameter BLINK_DIV, default 250: frames per blink half-period.
REQ-005 Port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port en, input, 1 bit: display enable.
REQ-008 Port digits_in, input, 4*N_DIG bits: nibble k = digit code for position k (bits 4k+3:4k).
REQ-009 Port blink_mask, input, N_DIG bits: bit k=1 makes position k blink.
REQ-010 Port digit, output, 4 bits, registered: code fed to the downstream 7-segment decoder; 4'hF = blank.
REQ-011 Port an, output, N_DIG bits, registered: active-low digit anode enables.
REQ-012 Port frame_tick, output, 1 bit, registered: one-cycle pulse at each frame boundary.

Function
REQ-013 The block SHALL count slot_cnt 0..SCAN_DIV-1 and wrap to 0; the wrap cycle is a slot tick.
REQ-014 On each slot tick idx SHALL advance by 1 modulo N_DIG; idx N_DIG-1 -> 0 is a frame boundary.
REQ-015 At a frame boundary, snap SHALL capture digits_in and blink_mask; mid-frame input changes are invisible until the next boundary (no tearing).
REQ-016 frame_tick SHALL be 1 for exactly the cycle after the frame-boundary edge, else 0.
REQ-017 frame_cnt SHALL count frames 0..BLINK_DIV-1; on its wrap blink_phase SHALL toggle.
REQ-018 Registered outputs SHALL reflect the post-edge slot_cnt and idx: if slot_cnt < GUARD, an = all ones; otherwise an = all ones except bit idx = 0.
REQ-019 digit SHALL be 4'hF when slot_cnt < GUARD or when snap blink bit idx = 1 and blink_phase = 1; otherwise snap nibble idx.
REQ-020 en = 0 SHALL force an = all ones and digit = 4'hF from the next edge; counters, idx, snapshot and blink SHALL keep running.
REQ-021 At most one anode SHALL be low in any cycle; no cycle SHALL have an anode low while digit changes.
REQ-022 Digit codes 10..14 SHALL pass through unmodified; the downstream decoder renders them.
REQ-023 SCAN_DIV > GUARD, N_DIG >= 2 and BLINK_DIV >= 1 are required; other values are unsupported.

Reset
REQ-024 rst_n low SHALL immediately set slot_cnt=0, idx=0, frame_cnt=0, blink_phase=0, snap digits=4'hF, snap blink=0, an=all ones, digit=4'hF, frame_tick=0.
REQ-025 Reset asserted mid-slot or mid-frame SHALL abort the scan; after release scanning SHALL restart at slot 0 with GUARD blanking.
REQ-026 The first snapshot of digits_in SHALL occur at the first frame boundary after reset release; until then all slots show 4'hF.

Verification (N_DIG=6, SCAN_DIV=8, GUARD=2, BLINK_DIV=3)
REQ-027 digits_in=24'h543210, en=1, run 2 frames -> frame 2: slots 0..5 show digit 0..5 with an=6'b111110, 111101, ... 011111 for cycles 2..7 of each slot, and all ones in cycles 0..1.
REQ-028 Change digits_in to 24'h999999 mid-frame -> the current frame keeps the old values; digit=9 from the first slot of the next frame.
REQ-029 blink_mask=6'b000100 -> slot 2 shows digit=4'hF with an still low for 3 frames, then its value for 3 frames, repeating; other slots are unaffected.
REQ-030 en=0 for 20 cycles mid-slot -> an=all ones and digit=4'hF next cycle; frame_tick still pulses every 48 cycles; on en=1 outputs resume at the current idx.
REQ-031 Pulse rst_n low for 1 cycle at slot 3 cycle 5 -> an=all ones and digit=4'hF immediately; the scan restarts at idx 0; the first non-blank digit appears only after a frame boundary.
REQ-032 Throughout all scenarios, a checker asserts the one-hot-low-or-all-ones property of an and frame_tick period = 48 cycles.

Source files
------------

// File: rtl/display_scan.sv
// display_scan: time-multiplexed 7-segment scanner with a frame-synchronous
// input snapshot, guard blanking at the start of every slot and per-digit blink.
module display_scan #(
  parameter int N_DIG     = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 4,
  parameter int BLINK_DIV = 250
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [4*N_DIG-1:0] digits_in,
  input  logic [N_DIG-1:0]   blink_mask,
  output logic [3:0]         digit,
  output logic [N_DIG-1:0]   an,
  output logic               frame_tick
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int IW = $clog2(N_DIG);
  localparam int FW = $clog2(BLINK_DIV + 1);

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] GUARD_V    = SW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  logic [SW-1:0]      r_slot_cnt;
  logic [IW-1:0]      r_idx;
  logic [FW-1:0]      r_frame_cnt;
  logic               r_blink_phase;
  logic [4*N_DIG-1:0] r_snap_dig;
  logic [N_DIG-1:0]   r_snap_blink;
  logic [N_DIG-1:0]   r_an;
  logic [3:0]         r_digit;
  logic               r_frame_tick;

  logic               w_slot_tick;
  logic               w_frame_edge;
  logic [SW-1:0]      w_slot_nxt;
  logic [IW-1:0]      w_idx_nxt;
  logic [FW-1:0]      w_frame_cnt_nxt;
  logic               w_blink_nxt;
  logic [4*N_DIG-1:0] w_snap_dig_nxt;
  logic [N_DIG-1:0]   w_snap_blink_nxt;
  logic               w_guard;
  logic [3:0]         w_nib;
  logic [N_DIG-1:0]   w_an_nxt;
  logic [3:0]         w_digit_nxt;

  // Next-state for slot/idx/frame counters; snapshot only moves at a frame boundary.
  always_comb begin
    w_slot_tick  = (r_slot_cnt == SLOT_LAST);
    w_frame_edge = w_slot_tick && (r_idx == IDX_LAST);

    if (w_slot_tick) begin
      w_slot_nxt = {SW{1'b0}};
    end else begin
      w_slot_nxt = r_slot_cnt + SW'(1);
    end

    if (!w_slot_tick) begin
      w_idx_nxt = r_idx;
    end else if (r_idx == IDX_LAST) begin
      w_idx_nxt = {IW{1'b0}};
    end else begin
      w_idx_nxt = r_idx + IW'(1);
    end

    w_snap_dig_nxt   = r_snap_dig;
    w_snap_blink_nxt = r_snap_blink;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_blink_nxt      = r_blink_phase;
    if (w_frame_edge) begin
      w_snap_dig_nxt   = digits_in;
      w_snap_blink_nxt = blink_mask;
      if (r_frame_cnt == FRAME_LAST) begin
        w_frame_cnt_nxt = {FW{1'b0}};
        w_blink_nxt     = ~r_blink_phase;
      end else begin
        w_frame_cnt_nxt = r_frame_cnt + FW'(1);
        w_blink_nxt     = r_blink_phase;
      end
    end else begin
      w_frame_cnt_nxt = r_frame_cnt;
      w_blink_nxt     = r_blink_phase;
    end
  end

  // Outputs are decoded from post-edge state so the anode and digit switch together.
  always_comb begin
    w_nib       = w_snap_dig_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_guard     = (w_slot_nxt < GUARD_V);
    w_an_nxt    = {N_DIG{1'b1}};
    w_digit_nxt = 4'hF;
    if (en && !w_guard) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
      if (w_snap_blink_nxt[w_idx_nxt] && w_blink_nxt) begin
        w_digit_nxt = 4'hF;
      end else begin
        w_digit_nxt = w_nib;
      end
    end else begin
      w_an_nxt    = {N_DIG{1'b1}};
      w_digit_nxt = 4'hF;
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt    <= {SW{1'b0}};
      r_idx         <= {IW{1'b0}};
      r_frame_cnt   <= {FW{1'b0}};
      r_blink_phase <= 1'b0;
      r_snap_dig    <= {N_DIG{4'hF}};
      r_snap_blink  <= {N_DIG{1'b0}};
    end else begin
      r_slot_cnt    <= w_slot_nxt;
      r_idx         <= w_idx_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_blink_phase <= w_blink_nxt;
      r_snap_dig    <= w_snap_dig_nxt;
      r_snap_blink  <= w_snap_blink_nxt;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= {N_DIG{1'b1}};
      r_digit      <= 4'hF;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_digit      <= w_digit_nxt;
      r_frame_tick <= w_frame_edge;
    end
  end

  assign an         = r_an;
  assign digit      = r_digit;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed stimulus with a per-cycle expected-value queue and an
// independent monitor that also watches anode one-hotness and frame_tick period.
`timescale 1ns/1ps
module tb_display_scan;

  localparam int N_DIG     = 6;
  localparam int SCAN_DIV  = 8;
  localparam int GUARD     = 2;
  localparam int BLINK_DIV = 3;
  localparam int FRAME     = N_DIG * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] digits_in;
  logic [5:0]  blink_mask;
  logic [3:0]  digit;
  logic [5:0]  an;
  logic        frame_tick;

  display_scan #(
    .N_DIG(N_DIG), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_in),
    .blink_mask(blink_mask), .digit(digit), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  an;
    logic [3:0]  digit;
    logic        ft;
    logic [31:0] t;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  int          m_t;
  logic [23:0] m_snap;
  logic [5:0]  m_mask;

  // Expected outputs for timeline position m_t, derived from slot/frame arithmetic.
  task automatic push_expect();
    exp_t        e;
    int          slot, idx, ph;
    logic [5:0]  one;
    logic [23:0] snap;
    one  = 6'b000001;
    snap = m_snap;
    slot = m_t % SCAN_DIV;
    idx  = (m_t / SCAN_DIV) % N_DIG;
    ph   = ((m_t / FRAME) / BLINK_DIV) % 2;
    e.an    = 6'h3F;
    e.digit = 4'hF;
    e.ft    = (m_t > 0) && (m_t % FRAME == 0);
    e.t     = m_t;
    if (en && slot >= GUARD) begin
      e.an = ~(one << idx);
      if (!(m_mask[idx] && ph == 1)) e.digit = snap[idx*4 +: 4];
    end
    q.push_back(e);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      m_t = m_t + 1;
      if (m_t % FRAME == 0) begin
        m_snap = digits_in;
        m_mask = blink_mask;
      end
      push_expect();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_now(input string tag);
    checks++;
    if (an !== 6'h3F) begin
      failures++;
      $display("FAIL %s_an actual=%b required=%b", tag, an, 6'h3F);
    end
    checks++;
    if (digit !== 4'hF) begin
      failures++;
      $display("FAIL %s_digit actual=%h required=%h", tag, digit, 4'hF);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL %s_ft actual=%b required=%b", tag, frame_tick, 1'b0);
    end
  endtask

  task automatic pulse_reset();
    exp_t e;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_now("midreset");
    m_t    = 0;
    m_snap = 24'hFFFFFF;
    m_mask = 6'h00;
    e.an = 6'h3F; e.digit = 4'hF; e.ft = 1'b0; e.t = 32'd0;
    q.push_back(e);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  exp_t       mon_e;
  int         cyc     = 0;
  int         last_ft = -1;
  logic [5:0] an_prev  = 6'h3F;
  logic [3:0] dig_prev = 4'hF;

  // Monitor: pops one expectation per displayed cycle and checks global properties.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) last_ft = -1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (an !== mon_e.an) begin
        failures++;
        $display("FAIL an t=%0d actual=%b required=%b", mon_e.t, an, mon_e.an);
      end
      checks++;
      if (digit !== mon_e.digit) begin
        failures++;
        $display("FAIL digit t=%0d actual=%h required=%h", mon_e.t, digit, mon_e.digit);
      end
      checks++;
      if (frame_tick !== mon_e.ft) begin
        failures++;
        $display("FAIL frame_tick t=%0d actual=%b required=%b", mon_e.t, frame_tick, mon_e.ft);
      end
    end
    checks++;
    if (!(an == 6'h3F || $countones(~an) == 1)) begin
      failures++;
      $display("FAIL an_onehot cyc=%0d actual=%b required=one-low-or-all-ones", cyc, an);
    end
    if (rst_n && frame_tick) begin
      if (last_ft >= 0) begin
        checks++;
        if (cyc - last_ft != FRAME) begin
          failures++;
          $display("FAIL ft_period actual=%0d required=%0d", cyc - last_ft, FRAME);
        end
      end
      last_ft = cyc;
    end
    if (digit !== dig_prev && an != 6'h3F && an_prev != 6'h3F) begin
      checks++;
      failures++;
      $display("FAIL ghost cyc=%0d actual=%h->%h required=digit-stable-while-lit", cyc, dig_prev, digit);
    end
    an_prev  = an;
    dig_prev = digit;
  end

  initial begin
    rst_n      = 1'b1;
    en         = 1'b0;
    digits_in  = 24'h000000;
    blink_mask = 6'h00;
    m_t        = 0;
    m_snap     = 24'hFFFFFF;
    m_mask     = 6'h00;
    #1 rst_n = 1'b0;
    #1 check_reset_now("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Blank first frame, then 0..5 in frame 1.
    en        = 1'b1;
    digits_in = 24'h543210;
    step(100);

    // Mid-frame change must not tear the current frame.
    while (m_t % FRAME != 20) step(1);
    digits_in = 24'h999999;
    step(60);

    // Codes A..E pass through; slot 2 blinks with a 3-frame half-period.
    digits_in  = 24'hEDCBA9;
    blink_mask = 6'b000100;
    step(FRAME * 7);

    // Display disable mid-slot.
    while (m_t % SCAN_DIV != 4) step(1);
    en = 1'b0;
    step(20);
    en = 1'b1;
    step(30);

    // Reset pulse at slot 3 cycle 5.
    while (m_t % FRAME != 29) step(1);
    pulse_reset();
    step(110);

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
